// File: rtl/wisard_rx_pkg.sv
// Shared definitions for the serial tuple receiver.
//   rx_state_e  : receiver FSM state (IDLE waits for sop, RECV collects bits)
//   ERR_*       : bit positions of the sticky error flags inside the
//                 receiver's error vector
package wisard_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    localparam int ERR_TRUNC   = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_STRAY   = 2;
    localparam int ERR_W       = 3;

endpackage

// File: rtl/tuple_shift_counter.sv
// Serial-to-parallel shift register with bit and tuple counters.
//   clk, rst     : clock, synchronous active-high reset
//   shift        : accept bit_in this cycle
//   restart      : bit_in is bit 0 of tuple 0 (partial state discarded)
//   bit_in       : serial data, MSB first
//   word_next    : tuple word including bit_in (valid when tuple_done)
//   tuple_idx    : index of the tuple bit_in belongs to
//   tuple_done   : bit_in completes a tuple
//   frame_wrap   : bit_in completes the last tuple of the frame
// Requires ADDRESS_WIDTH >= 2.
module tuple_shift_counter #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int N_RAMS        = 8,
    parameter int INDEX_WIDTH   = $clog2(N_RAMS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift,
    input  logic                     restart,
    input  logic                     bit_in,
    output logic [ADDRESS_WIDTH-1:0] word_next,
    output logic [INDEX_WIDTH-1:0]   tuple_idx,
    output logic                     tuple_done,
    output logic                     frame_wrap
);

    localparam int BIT_W = (ADDRESS_WIDTH > 1) ? $clog2(ADDRESS_WIDTH) : 1;

    logic [ADDRESS_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]         bit_cnt;
    logic [INDEX_WIDTH-1:0]   tup_cnt;

    // On restart the bit is evaluated as if all state were already zero,
    // so the same next-state logic serves both the normal and restart paths.
    logic [ADDRESS_WIDTH-1:0] base;
    logic [BIT_W-1:0]         eff_bit;
    logic [INDEX_WIDTH-1:0]   eff_tup;

    always_comb begin
        base       = restart ? '0 : shreg;
        eff_bit    = restart ? '0 : bit_cnt;
        eff_tup    = restart ? '0 : tup_cnt;
        word_next  = {base[ADDRESS_WIDTH-2:0], bit_in};
        tuple_idx  = eff_tup;
        tuple_done = shift && (eff_bit == BIT_W'(ADDRESS_WIDTH - 1));
        frame_wrap = tuple_done && (eff_tup == INDEX_WIDTH'(N_RAMS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            tup_cnt <= '0;
        end else if (shift) begin
            shreg <= word_next;
            if (tuple_done) begin
                bit_cnt <= '0;
                tup_cnt <= frame_wrap ? '0 : eff_tup + INDEX_WIDTH'(1);
            end else begin
                bit_cnt <= eff_bit + BIT_W'(1);
                tup_cnt <= eff_tup;
            end
        end
    end

endmodule

// File: rtl/tuple_stream_rx.sv
// Serial tuple-address receiver. Reassembles ADDRESS_WIDTH-bit tuples from a
// one-bit stream (framed by sop) and presents them with their RAM index on a
// valid/ready output. Sticky error flags report truncated frames, output
// overruns and stray bits.
//   clk, rst                  : clock, synchronous active-high reset
//   sop, sink_valid, addr     : serial input (no backpressure)
//   tuple_addr/index/valid    : output tuple, held until tuple_ready
//   tuple_ready               : consumer handshake
//   tuple_last                : output tuple is the frame's last
//   frame_done                : pulse after a clean frame's last tuple is taken
//   err_trunc/overrun/stray   : sticky error flags
module tuple_stream_rx
    import wisard_rx_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int N_RAMS        = 8,
    parameter int INDEX_WIDTH   = $clog2(N_RAMS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sop,
    input  logic                     sink_valid,
    input  logic                     addr,
    output logic [ADDRESS_WIDTH-1:0] tuple_addr,
    output logic [INDEX_WIDTH-1:0]   tuple_index,
    output logic                     tuple_valid,
    input  logic                     tuple_ready,
    output logic                     tuple_last,
    output logic                     frame_done,
    output logic                     err_trunc,
    output logic                     err_overrun,
    output logic                     err_stray
);

    rx_state_e          state;
    logic [ERR_W-1:0]   err_q;
    logic               frame_bad;  // current input frame has overrun
    logic               out_bad;    // held tuple belongs to a bad frame
    logic               last_q;

    logic                     shift, restart, trunc, stray;
    logic [ADDRESS_WIDTH-1:0] word_next;
    logic [INDEX_WIDTH-1:0]   tuple_idx;
    logic                     tuple_done, frame_wrap;
    logic                     accept, load, overrun;

    tuple_shift_counter #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .N_RAMS       (N_RAMS),
        .INDEX_WIDTH  (INDEX_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .shift     (shift),
        .restart   (restart),
        .bit_in    (addr),
        .word_next (word_next),
        .tuple_idx (tuple_idx),
        .tuple_done(tuple_done),
        .frame_wrap(frame_wrap)
    );

    always_comb begin
        shift   = 1'b0;
        restart = 1'b0;
        trunc   = 1'b0;
        stray   = 1'b0;
        if (sink_valid) begin
            case (state)
                IDLE: begin
                    if (sop) begin
                        shift   = 1'b1;
                        restart = 1'b1;
                    end else begin
                        stray = 1'b1;
                    end
                end
                RECV: begin
                    // Frame completion always returns to IDLE, so any sop
                    // seen in RECV interrupts a frame in progress.
                    shift   = 1'b1;
                    restart = sop;
                    trunc   = sop;
                end
                default: ;
            endcase
        end
        accept  = tuple_valid && tuple_ready;
        load    = tuple_done && (!tuple_valid || tuple_ready);
        overrun = tuple_done && tuple_valid && !tuple_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            err_q       <= '0;
            frame_bad   <= 1'b0;
            out_bad     <= 1'b0;
            last_q      <= 1'b0;
            tuple_addr  <= '0;
            tuple_index <= '0;
            tuple_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (shift)
                state <= frame_wrap ? IDLE : RECV;

            if (shift && restart)
                frame_bad <= 1'b0;
            if (overrun)
                frame_bad <= 1'b1;

            if (load) begin
                tuple_addr  <= word_next;
                tuple_index <= tuple_idx;
                tuple_valid <= 1'b1;
                last_q      <= frame_wrap;
                out_bad     <= restart ? 1'b0 : frame_bad;
            end else if (accept) begin
                tuple_valid <= 1'b0;
            end

            frame_done <= accept && last_q && !out_bad;

            err_q[ERR_TRUNC]   <= err_q[ERR_TRUNC]   | trunc;
            err_q[ERR_OVERRUN] <= err_q[ERR_OVERRUN] | overrun;
            err_q[ERR_STRAY]   <= err_q[ERR_STRAY]   | stray;
        end
    end

    assign tuple_last  = tuple_valid && last_q;
    assign err_trunc   = err_q[ERR_TRUNC];
    assign err_overrun = err_q[ERR_OVERRUN];
    assign err_stray   = err_q[ERR_STRAY];

endmodule

// File: tb/tb_tuple_stream_rx.sv
module tb_tuple_stream_rx;

    localparam int AW = 4;
    localparam int NR = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst, sop, sink_valid, addr, tuple_ready;
    logic [AW-1:0] tuple_addr;
    logic [IW-1:0] tuple_index;
    logic          tuple_valid, tuple_last, frame_done;
    logic          err_trunc, err_overrun, err_stray;

    tuple_stream_rx #(.ADDRESS_WIDTH(AW), .N_RAMS(NR), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .sop(sop), .sink_valid(sink_valid), .addr(addr),
        .tuple_addr(tuple_addr), .tuple_index(tuple_index),
        .tuple_valid(tuple_valid), .tuple_ready(tuple_ready),
        .tuple_last(tuple_last), .frame_done(frame_done),
        .err_trunc(err_trunc), .err_overrun(err_overrun), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    // frame_done observed at the edge after it is registered
    always @(posedge clk) if (frame_done) fd_cnt++;

    typedef struct {
        logic       s, v, a;
        logic       ev;
        logic [3:0] ea;
        logic [1:0] ei;
        logic       el, efd;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic a);
        sop = s; sink_valid = v; addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sop = 1'b0; sink_valid = 1'b0; addr = 1'b0; tuple_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [2:0] errs();
        return {err_stray, err_overrun, err_trunc};
    endfunction

    // Sends a 3-tuple frame with ready held high; gap idle cycles (sop high,
    // sink_valid low) follow every bit. Checks each tuple right after its last bit.
    task automatic send_frame(input string nm, input logic [11:0] bits, input int gap);
        for (int i = 0; i < 12; i++) begin
            cyc(i == 0, 1'b1, bits[11-i]);
            if (i % 4 == 3) begin
                int j;
                logic [3:0] ew;
                j  = i / 4;
                ew = bits[11-4*j -: 4];
                chk($sformatf("%s_tuple%0d", nm, j),
                    {tuple_valid, tuple_addr, tuple_index, tuple_last},
                    {1'b1, ew, 2'(j), (j == 2)});
            end
            for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, 1'b0);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [11:0] b;
        int fd0;
        b = 12'hA6F;

        // ---- reset state ----
        do_reset();
        chk("reset_state",
            {tuple_addr, tuple_index, tuple_valid, tuple_last, frame_done, errs()}, 32'h0);

        // ---- clean contiguous frame, cycle-accurate table ----
        for (int i = 0; i < 14; i++) begin
            tbl[i].s = (i == 0); tbl[i].v = (i < 12); tbl[i].a = (i < 12) ? b[11-i] : 1'b0;
            tbl[i].ev = 1'b0; tbl[i].ea = 4'h0; tbl[i].ei = 2'd0; tbl[i].el = 1'b0; tbl[i].efd = 1'b0;
        end
        tbl[3].ev  = 1'b1; tbl[3].ea  = 4'hA; tbl[3].ei  = 2'd0;
        tbl[7].ev  = 1'b1; tbl[7].ea  = 4'h6; tbl[7].ei  = 2'd1;
        tbl[11].ev = 1'b1; tbl[11].ea = 4'hF; tbl[11].ei = 2'd2; tbl[11].el = 1'b1;
        tbl[12].efd = 1'b1;
        tuple_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].a);
            chk($sformatf("vec%0d", i),
                {tuple_valid, tuple_valid ? tuple_addr : 4'h0, tuple_valid ? tuple_index : 2'd0,
                 tuple_last, frame_done, errs()},
                {tbl[i].ev, tbl[i].ea, tbl[i].ei, tbl[i].el, tbl[i].efd, 3'b000});
        end

        // ---- gapped frame; sop without sink_valid in gaps must be ignored ----
        do_reset();
        fd0 = fd_cnt;
        send_frame("gap", b, 1);
        chk("gap_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("gap_errs", {29'd0, errs()}, 32'h0);

        // ---- ready low throughout: overrun, first tuple held ----
        do_reset();
        tuple_ready = 1'b0;
        fd0 = fd_cnt;
        for (int i = 0; i < 12; i++) begin
            cyc(i == 0, 1'b1, b[11-i]);
            if (i == 3) chk("ovr_t0", {tuple_valid, tuple_addr, tuple_index}, {1'b1, 4'hA, 2'd0});
            if (i == 6) chk("ovr_before", {31'd0, err_overrun}, 32'd0);
            if (i == 7) chk("ovr_flag", {tuple_valid, tuple_addr, tuple_index, err_overrun},
                            {1'b1, 4'hA, 2'd0, 1'b1});
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("ovr_held", {tuple_valid, tuple_addr, tuple_index, tuple_last}, {1'b1, 4'hA, 2'd0, 1'b0});
        chk("ovr_no_done", 32'(fd_cnt - fd0), 32'd0);

        // ---- accept and new load on the same edge: no overrun ----
        do_reset();
        tuple_ready = 1'b0;
        fd0 = fd_cnt;
        for (int i = 0; i < 12; i++) begin
            if (i == 7) tuple_ready = 1'b1;
            cyc(i == 0, 1'b1, b[11-i]);
            if (i == 6) chk("same_hold", {tuple_valid, tuple_addr}, {1'b1, 4'hA});
            if (i == 7) chk("same_load", {tuple_valid, tuple_addr, tuple_index, err_overrun},
                            {1'b1, 4'h6, 2'd1, 1'b0});
            if (i == 8) chk("same_drop", {31'd0, tuple_valid}, 32'd0);
            if (i == 11) chk("same_last", {tuple_valid, tuple_addr, tuple_index, tuple_last},
                             {1'b1, 4'hF, 2'd2, 1'b1});
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("same_done", 32'(fd_cnt - fd0), 32'd1);
        chk("same_errs", {29'd0, errs()}, 32'h0);

        // ---- truncation: sop at bit 6 ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(i == 0, 1'b1, b[11-i]);
            if (i == 3) chk("trunc_first", {tuple_valid, tuple_addr, tuple_index}, {1'b1, 4'hA, 2'd0});
        end
        chk("trunc_pre", {31'd0, err_trunc}, 32'd0);
        send_frame("trunc", 12'h123, 0);
        chk("trunc_errs", {29'd0, errs()}, 32'b001);

        // ---- stray bits without sop ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk($sformatf("stray_nv%0d", i), {31'd0, tuple_valid}, 32'd0);
        end
        chk("stray_errs", {29'd0, errs()}, 32'b100);

        // ---- reset mid-frame, then clean frame ----
        do_reset();
        for (int i = 0; i < 5; i++) cyc(i == 0, 1'b1, b[11-i]);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("midrst_zero",
            {tuple_addr, tuple_index, tuple_valid, tuple_last, frame_done, errs()}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        fd0 = fd_cnt;
        send_frame("midrst", b, 0);
        chk("midrst_done", 32'(fd_cnt - fd0), 32'd1);
        chk("midrst_errs", {29'd0, errs()}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tuple_stream_rx.md
TUPLE_STREAM_RX -- requirements
Module: tuple_stream_rx

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 4: bits per tuple address.
REQ-002 Parameter N_RAMS, default 8: tuples per sample frame.
REQ-003 Parameter INDEX_WIDTH, default $clog2(N_RAMS): tuple index width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sop  input  1  start of sample; qualified by sink_valid; marks first bit of a frame.
REQ-007 sink_valid  input  1  addr bit valid this cycle; no backpressure.
REQ-008 addr  input  1  serial tuple bit, MSB of tuple 0 first.
REQ-009 tuple_addr  output  ADDRESS_WIDTH  reassembled tuple address.
REQ-010 tuple_index  output  INDEX_WIDTH  RAM index of tuple_addr (0..N_RAMS-1).
REQ-011 tuple_valid  output  1  tuple_addr/tuple_index valid.
REQ-012 tuple_ready  input  1  consumer accepts when tuple_valid && tuple_ready.
REQ-013 tuple_last  output  1  tuple_index == N_RAMS-1, qualified by tuple_valid.
REQ-014 frame_done  output  1  one-cycle pulse when a complete frame's last tuple is accepted.
REQ-015 err_trunc  output  1  sticky: sop arrived mid-frame.
REQ-016 err_overrun  output  1  sticky: tuple completed while output still held.
REQ-017 err_stray  output  1  sticky: valid bit received in IDLE without sop.

Function
REQ-018 FSM states IDLE, RECV; reset to IDLE.
REQ-019 IDLE: sink_valid && sop -> RECV, bit stored as bit 0 of tuple 0; sink_valid && !sop -> bit dropped, err_stray set, stay IDLE.
REQ-020 RECV: each sink_valid cycle shifts addr into LSB of shift register (first bit ends at MSB); cycles with sink_valid low hold all state.
REQ-021 Bit counter 0..ADDRESS_WIDTH-1 wraps to 0 on tuple completion; tuple counter 0..N_RAMS-1 increments per completed tuple.
REQ-022 On ADDRESS_WIDTH-th bit at cycle t, tuple_addr/tuple_index loaded and tuple_valid high at t+1 (latency 1).
REQ-023 tuple_valid, tuple_addr, tuple_index stable until handshake; clears cycle after accept unless new tuple loads same cycle.
REQ-024 Accept and new-tuple load in same cycle: new tuple loads, tuple_valid stays high, no overrun.
REQ-025 Tuple completes while tuple_valid && !tuple_ready: new tuple discarded, held tuple kept, err_overrun set; frame counting continues.
REQ-026 Completion of tuple N_RAMS-1 returns FSM to IDLE same edge; next frame requires sop.
REQ-027 sop with sink_valid in RECV at any bit position other than a frame start: err_trunc set, counters reset, bit taken as bit 0 of tuple 0; partial tuple discarded; pending output tuple unaffected.
REQ-028 frame_done pulses on accept of tuple_last only if frame had no truncation or overrun.
REQ-029 sop without sink_valid ignored.

Reset
REQ-030 rst: FSM IDLE, counters 0, shift register 0, tuple_addr 0, tuple_index 0, tuple_valid 0, frame_done 0, all err_* 0.
REQ-031 rst mid-frame discards partial frame and pending output; first post-reset bit treated as IDLE input.

Structure
REQ-032 Shared package wisard_rx_pkg holds FSM state typedef (IDLE, RECV) and error-flag bit positions.
REQ-033 One sub-module tuple_shift_counter: shift register plus bit/tuple counters with wrap outputs; FSM, output register, flags in top.

Verification (ADDRESS_WIDTH=4, N_RAMS=3)
REQ-034 sop on bit 0, 12 contiguous bits 1010_0110_1111, tuple_ready=1 -> tuples (0xA,0),(0x6,1),(0xF,2), each one cycle after its 4th bit, tuple_last on index 2, frame_done once, no errors.
REQ-035 Same frame with sink_valid low every other cycle -> identical tuples, each one cycle after its final valid bit.
REQ-036 tuple_ready=0 throughout frame -> (0xA,0) held, err_overrun=1 after tuple 1 completes, frame_done never pulses.
REQ-037 sop at bit 6 of frame, then 12 bits 0001_0010_0011 -> err_trunc=1, tuples (0x1,0),(0x2,1),(0x3,2); tuple (0xA,0) from first frame still delivered.
REQ-038 Three valid bits without sop from reset -> no tuple_valid, err_stray=1.
REQ-039 rst asserted after 5 bits, then clean frame -> all outputs 0 during reset, clean frame decoded as REQ-034, no error flags.
